// File: rtl/fetch_decode_reg_if.sv
// Instruction-memory read channel between the fetch stage and the memory.
// The fetch stage is the master: it raises imem_req with a word-aligned
// imem_addr and holds both until the memory answers with imem_ack/imem_rdata.
interface fetch_decode_reg_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_decode_reg.sv
// Fetch stage plus IF/ID pipeline register.
// A four-state controller issues one instruction-memory read at a time. Each
// returned word goes straight into the ID register when it can accept it, or
// into a one-entry skid buffer while the decode stage stalls. A redirect
// abandons the outstanding read (its late data is drained and dropped) and
// restarts fetching at the new target.
module fetch_decode_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fetch_decode_reg_if.master        imem,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      id_valid,
    output logic [31:0]               id_pc,
    output logic [31:0]               id_instr,
    output logic [5:0]                id_opcode,
    output logic [4:0]                id_rs,
    output logic [4:0]                id_rt,
    output logic [4:0]                id_rd,
    output logic [5:0]                id_funct,
    output logic [15:0]               id_imm16,
    output logic [25:0]               id_jtarget
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic        load_ok;
    logic [31:0] pc_inc;

    // The ID register may take a new word when it is empty or not stalled.
    assign load_ok = !id_valid_q || !stall;
    assign pc_inc  = pc_q + 32'd4;

    // Next-state, fetch-address and pipeline-register update logic.
    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned; that keeps this block free of latches.
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        unique case (state_q)
            IDLE: begin
                // Any ack seen here belongs to a transaction killed by reset.
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = redirect_valid ? redirect_pc : pc_q;
            end

            FETCH: begin
                if (redirect_valid) begin
                    if (imem.imem_ack) begin
                        addr_d = redirect_pc;
                    end else begin
                        // Read still in flight: keep its address until it lands.
                        state_d = DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    pc_d = pc_inc;
                    if (flush) begin
                        // The word is consumed but never becomes live.
                        addr_d = pc_inc;
                    end else if (load_ok) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = addr_q;
                        id_instr_d = imem.imem_rdata;
                        addr_d     = pc_inc;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = addr_q;
                        skid_instr_d = imem.imem_rdata;
                        state_d      = HOLD;
                        req_d        = 1'b0;
                        addr_d       = pc_inc;
                    end
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = redirect_pc;
                end else if (!flush && load_ok) begin
                    id_valid_d   = 1'b1;
                    id_pc_d      = skid_pc_q;
                    id_instr_d   = skid_instr_q;
                    skid_valid_d = 1'b0;
                    state_d      = FETCH;
                    req_d        = 1'b1;
                    addr_d       = pc_q;
                end
            end

            DRAIN: begin
                if (imem.imem_ack) begin
                    state_d = FETCH;
                    addr_d  = redirect_valid ? redirect_pc : pc_q;
                end
            end
        endcase

        // Invalidation overrides any load decided above.
        if (flush || redirect_valid) begin
            id_valid_d = 1'b0;
        end
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            skid_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values, independent of statement order.
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign id_valid   = id_valid_q;
    assign id_pc      = id_pc_q;
    assign id_instr   = id_instr_q;

    // Fixed instruction fields; id_imm16 is the operand of the decode-stage
    // sign extender.
    assign id_opcode  = id_instr_q[31:26];
    assign id_rs      = id_instr_q[25:21];
    assign id_rt      = id_instr_q[20:16];
    assign id_rd      = id_instr_q[15:11];
    assign id_funct   = id_instr_q[5:0];
    assign id_imm16   = id_instr_q[15:0];
    assign id_jtarget = id_instr_q[25:0];

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Self-checking bench for fetch_decode_reg: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_fetch_decode_reg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm16;
    logic [25:0] id_jtarget;

    fetch_decode_reg_if bus ();

    fetch_decode_reg #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_funct       (id_funct),
        .id_imm16       (id_imm16),
        .id_jtarget     (id_jtarget)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    bit          m_idle;      // first cycle after reset: nothing issued yet
    bit          m_req;       // a read is outstanding
    bit          m_zombie;    // the outstanding read was overtaken by a redirect
    logic [31:0] m_addr;      // address of the outstanding read
    logic [31:0] m_pc;        // next sequential fetch address
    bit          m_id_valid;
    word_t       m_id;
    word_t       m_skid[$];

    function automatic void model_reset();
        m_idle     = 1'b1;
        m_req      = 1'b0;
        m_zombie   = 1'b0;
        m_addr     = RESET_PC;
        m_pc       = RESET_PC;
        m_id_valid = 1'b0;
        m_id       = '0;
        m_skid.delete();
    endfunction

    function automatic void model_step(input bit ack, input logic [31:0] rdata, input bit st,
                                       input bit fl, input bit rv, input logic [31:0] rpc);
        bit got     = m_req && ack;
        bit can_ld  = !m_id_valid || !st;
        if (m_idle) begin
            m_idle = 1'b0;
            m_req  = 1'b1;
            m_addr = m_pc;
            return;
        end
        if (rv) begin
            m_id_valid = 1'b0;
            m_skid.delete();
            m_pc = rpc;
            if (!m_req || got) begin
                m_req    = 1'b1;
                m_addr   = rpc;
                m_zombie = 1'b0;
            end else begin
                m_zombie = 1'b1;
            end
        end else if (got) begin
            if (m_zombie) begin
                m_zombie = 1'b0;
                m_addr   = m_pc;
            end else begin
                word_t w;
                w.pc    = m_addr;
                w.instr = rdata;
                m_pc    = m_pc + 32'd4;
                if (fl) begin
                    m_id_valid = 1'b0;
                    m_addr     = m_pc;
                end else if (can_ld) begin
                    m_id       = w;
                    m_id_valid = 1'b1;
                    m_addr     = m_pc;
                end else begin
                    m_skid.push_back(w);
                    m_req = 1'b0;
                end
            end
        end else if (m_skid.size() != 0) begin
            if (fl) begin
                m_id_valid = 1'b0;
            end else if (can_ld) begin
                m_id       = m_skid.pop_front();
                m_id_valid = 1'b1;
                m_req      = 1'b1;
                m_addr     = m_pc;
            end
        end else if (fl) begin
            m_id_valid = 1'b0;
        end
    endfunction

    task automatic check_outputs();
        check("imem_req", bus.imem_req, m_req);
        if (m_req) check("imem_addr", bus.imem_addr, m_addr);
        check("id_valid", id_valid, m_id_valid);
        check("id_pc", id_pc, m_id.pc);
        check("id_instr", id_instr, m_id.instr);
        check("id_opcode", id_opcode, m_id.instr >> 26);
        check("id_rs", id_rs, (m_id.instr >> 21) & 32'h1F);
        check("id_rt", id_rt, (m_id.instr >> 16) & 32'h1F);
        check("id_rd", id_rd, (m_id.instr >> 11) & 32'h1F);
        check("id_funct", id_funct, m_id.instr & 32'h3F);
        check("id_imm16", id_imm16, m_id.instr & 32'hFFFF);
        check("id_jtarget", id_jtarget, m_id.instr & 32'h03FF_FFFF);
    endtask

    // Drive one cycle's inputs (called at a falling edge), then check at the next falling edge.
    task automatic cycle(input bit ack, input logic [31:0] rdata, input bit st,
                         input bit fl, input bit rv, input logic [31:0] rpc);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        stall           = st;
        flush           = fl;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        model_step(ack, rdata, st, fl, rv, rpc);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, bus.imem_req, 1'b0);
        check({tag, "_addr"}, bus.imem_addr, RESET_PC);
        check({tag, "_valid"}, id_valid, 1'b0);
        check({tag, "_pc"}, id_pc, 32'h0);
        check({tag, "_instr"}, id_instr, 32'h0);
        check({tag, "_opcode"}, id_opcode, 32'h0);
        check({tag, "_imm16"}, id_imm16, 32'h0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        // Reset release: IDLE -> FETCH at RESET_PC, then the first word loads.
        cycle(0, 32'h0, 0, 0, 0, 32'h0);
        check("first_addr", bus.imem_addr, 32'h0);
        cycle(1, 32'h2108_FFFC, 0, 0, 0, 32'h0);
        check("ld_valid", id_valid, 1'b1);
        check("ld_pc", id_pc, 32'h0);
        check("ld_imm16", id_imm16, 32'hFFFC);
        check("ld_rs", id_rs, 32'd8);
        check("ld_rt", id_rt, 32'd8);
        check("ld_next_addr", bus.imem_addr, 32'h4);

        // Stalled ack goes to the skid buffer; released stall moves it into ID.
        cycle(1, 32'h8C22_0010, 1, 0, 0, 32'h0);
        check("hold_req", bus.imem_req, 1'b0);
        check("hold_instr", id_instr, 32'h2108_FFFC);
        check("hold_pc", id_pc, 32'h0);
        cycle(0, 32'h0, 0, 0, 0, 32'h0);
        check("unskid_instr", id_instr, 32'h8C22_0010);
        check("unskid_pc", id_pc, 32'h4);
        check("unskid_req", bus.imem_req, 1'b1);
        check("unskid_addr", bus.imem_addr, 32'h8);

        // Redirect with a read in flight: drain it, then fetch the target.
        cycle(0, 32'h0, 0, 0, 1, 32'h0000_0100);
        check("drain_valid", id_valid, 1'b0);
        check("drain_addr", bus.imem_addr, 32'h8);
        cycle(1, 32'hBAD0_BAD0, 0, 0, 0, 32'h0);
        check("drained_valid", id_valid, 1'b0);
        check("redir_addr", bus.imem_addr, 32'h100);
        cycle(1, 32'h0123_4567, 0, 0, 0, 32'h0);
        check("redir_pc", id_pc, 32'h100);

        // Flush together with stall empties ID; the next ack loads normally.
        cycle(0, 32'h0, 1, 1, 0, 32'h0);
        check("flush_valid", id_valid, 1'b0);
        cycle(1, 32'h89AB_CDEF, 1, 0, 0, 32'h0);
        check("post_flush_valid", id_valid, 1'b1);
        check("post_flush_pc", id_pc, 32'h104);

        // Fetch address wraps from the top of the address space.
        cycle(1, 32'h1111_1111, 0, 0, 1, 32'hFFFF_FFFC);
        check("wrap_target", bus.imem_addr, 32'hFFFF_FFFC);
        cycle(1, 32'h2222_2222, 0, 0, 0, 32'h0);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_addr", bus.imem_addr, 32'h0);

        // Reset asserted while in HOLD acts immediately; late acks are ignored.
        cycle(1, 32'h3333_3333, 1, 0, 0, 32'h0);
        check("pre_rst_req", bus.imem_req, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        model_reset();
        bus.imem_ack = 1'b1;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        cycle(1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
        check("rerst_valid", id_valid, 1'b0);
        check("rerst_addr", bus.imem_addr, RESET_PC);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          a  = m_req && ($urandom_range(99) < 60);
            bit          st = ($urandom_range(99) < 35);
            bit          fl = ($urandom_range(99) < 5);
            bit          rv = ($urandom_range(99) < 6);
            logic [31:0] rpc;
            rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            cycle(a, $urandom(), st, fl, rv, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_decode_reg.md
FETCH_DECODE_REG -- requirements
Module: fetch_decode_reg

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1, the instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, the fetch address, word aligned.
REQ-006 SHALL have port imem_ack, input, 1, read-data-valid for the outstanding request.
REQ-007 SHALL have port imem_rdata, input, 32, the instruction word, valid with imem_ack.
REQ-008 SHALL have port stall, input, 1, downstream hold; the ID register keeps its value.
REQ-009 SHALL have port flush, input, 1, invalidates the ID register.
REQ-010 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-011 SHALL have port redirect_pc, input, 32, the redirect target, sampled with redirect_valid.
REQ-012 SHALL have port id_valid, output, 1, the ID register holds a live instruction.
REQ-013 SHALL have port id_pc, output, 32, the fetch address of the ID instruction.
REQ-014 SHALL have port id_instr, output, 32, the ID instruction word.
REQ-015 SHALL have ports id_opcode[5:0], id_rs[4:0], id_rt[4:0], id_rd[4:0], id_funct[5:0], id_imm16[15:0] and id_jtarget[25:0], outputs, fixed slices of id_instr; id_imm16 feeds the sign-extension operand.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, HOLD, DRAIN; imem_req and imem_addr SHALL be registered; imem_req SHALL be 1 only in FETCH and DRAIN.
REQ-017 IDLE SHALL go to FETCH on the first clock after rst_n deasserts, with imem_addr = pc.
REQ-018 imem_addr SHALL stay constant while imem_req=1 and imem_ack=0.
REQ-019 Load condition: load_ok = !id_valid || !stall.
REQ-020 In FETCH, imem_ack with load_ok SHALL load the ID register on the same edge: id_instr=imem_rdata, id_pc=imem_addr, id_valid=1, pc=pc+4 with 32-bit wrap; the FSM stays in FETCH.
REQ-021 In FETCH, imem_ack without load_ok SHALL store the word and its address in a one-entry skid buffer, set pc=pc+4, and go to HOLD.
REQ-022 HOLD SHALL move the skid contents into the ID register on the first edge where load_ok=1, then go to FETCH.
REQ-023 While stall=1 and id_valid=1, all id_* outputs SHALL hold their values.
REQ-024 A stall with an empty ID register (id_valid=0) SHALL NOT block loading.
REQ-025 flush SHALL clear id_valid on the next edge, with priority over any load that cycle; the skid buffer and pc are unaffected unless redirect_valid=1.
REQ-026 redirect_valid SHALL clear id_valid, discard any skid entry, and set pc=redirect_pc.
REQ-027 On a redirect in FETCH with no ack that cycle, the FSM SHALL go to DRAIN, keeping the old imem_addr.
REQ-028 On a redirect in FETCH or DRAIN with ack that cycle, or on a redirect in HOLD, the FSM SHALL go to FETCH with imem_addr = redirect_pc.
REQ-029 DRAIN SHALL discard the ack data, then go to FETCH at the stored pc.
REQ-030 redirect_valid SHALL take priority over stall, flush, and load.
REQ-031 A redirect during DRAIN SHALL update pc and remain in DRAIN.
REQ-032 Fetch latency SHALL be one cycle from imem_ack to id_valid=1 when load_ok=1.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0 (all decoded fields 0), skid buffer empty.
REQ-034 Asserting rst_n mid-transaction SHALL abandon it immediately; any later imem_ack before the first FETCH SHALL be ignored.

Verification
REQ-035 Bench: reset release, ack on the 2nd cycle with rdata=32'h2108_FFFC -> imem_addr=0, id_valid=1, id_pc=0, id_imm16=16'hFFFC, id_rs=8, id_rt=8, next imem_addr=4.
REQ-036 Bench: id_valid=1, stall=1, ack with rdata=32'h8C22_0010 at address 4 -> HOLD, imem_req=0, ID unchanged; stall=0 -> id_instr=32'h8C22_0010, id_pc=4, FETCH at address 8.
REQ-037 Bench: FETCH outstanding at address 8, redirect_valid=1 with redirect_pc=32'h0000_0100 -> id_valid=0, DRAIN holds address 8; ack data discarded; next request at 32'h100.
REQ-038 Bench: flush=1 and stall=1 together with id_valid=1 -> id_valid=0 next edge; the following ack loads normally.
REQ-039 Bench: pc=32'hFFFF_FFFC, ack -> pc wraps to 0.
REQ-040 Bench: rst_n low while in HOLD -> all outputs at reset values asynchronously; after release, first request at RESET_PC.
